// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the key debouncer slice.
package key_debounce_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int SYNC_STAGES_DEF     = 2;

    // Two stable states plus one timing state per direction of change.
    typedef enum logic [1:0] {
        ST_HIGH      = 2'b00,
        ST_FILT_LOW  = 2'b01,
        ST_LOW       = 2'b10,
        ST_FILT_HIGH = 2'b11
    } state_t;

    // Stable state that corresponds to a given debounced level.
    function automatic state_t stableState(input logic level);
        return level ? ST_HIGH : ST_LOW;
    endfunction

    // True for the states in which a candidate level is being timed.
    function automatic logic isFiltState(input state_t st);
        return (st == ST_FILT_LOW) || (st == ST_FILT_HIGH);
    endfunction

endpackage

// File: rtl/key_debounce_sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous 1-bit level into clk.
module sync_chain #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the raw level through the chain; reset loads the idle level so no false edge appears.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/key_debounce.sv
// Key debouncer: synchronises a bouncing key level and only accepts a new
// level once it has been seen stable for DEBOUNCE_CYCLES consecutive clocks.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_out,
    output logic filtering
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             w_s;
    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nextCnt;
    logic             r_keyOut;
    logic             w_nextKeyOut;
    logic             r_filtering;
    logic             w_nextFiltering;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (IDLE_LEVEL)
    ) u_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (key_in),
        .o_q     (w_s)
    );

    // Next-state logic: a reversal of the synchronised level abandons the candidate with no credit kept.
    always_comb begin
        w_nextState  = r_state;
        w_nextCnt    = r_cnt;
        w_nextKeyOut = r_keyOut;
        case (r_state)
            ST_HIGH: begin
                if (!w_s) begin
                    w_nextState = ST_FILT_LOW;
                    w_nextCnt   = '0;
                end
            end
            ST_FILT_LOW: begin
                if (w_s) begin
                    w_nextState = ST_HIGH;
                    w_nextCnt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_nextState  = ST_LOW;
                    w_nextKeyOut = 1'b0;
                    w_nextCnt    = '0;
                end else begin
                    w_nextCnt = r_cnt + CNT_ONE;
                end
            end
            ST_LOW: begin
                if (w_s) begin
                    w_nextState = ST_FILT_HIGH;
                    w_nextCnt   = '0;
                end
            end
            ST_FILT_HIGH: begin
                if (!w_s) begin
                    w_nextState = ST_LOW;
                    w_nextCnt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_nextState  = ST_HIGH;
                    w_nextKeyOut = 1'b1;
                    w_nextCnt    = '0;
                end else begin
                    w_nextCnt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_nextState  = stableState(IDLE_LEVEL);
                w_nextCnt    = '0;
                w_nextKeyOut = IDLE_LEVEL;
            end
        endcase
        w_nextFiltering = isFiltState(w_nextState);
    end

    // State, counter and both outputs are registered together so filtering always matches the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= stableState(IDLE_LEVEL);
            r_cnt       <= '0;
            r_keyOut    <= IDLE_LEVEL;
            r_filtering <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_cnt       <= w_nextCnt;
            r_keyOut    <= w_nextKeyOut;
            r_filtering <= w_nextFiltering;
        end
    end

    assign key_out   = r_keyOut;
    assign filtering = r_filtering;

endmodule
